axi4_master_rd_burst: RTL and testbench
=======================================

# axi4_master_rd_burst

Command-driven AXI4 read initiator. Converts one (start address, beat count) command into a sequence of INCR read bursts, obeying the 256-beat and 4 KB limits, and streams returned data out on a valid/ready port. It sits on the initiator side of the fabric and fetches from read-only slaves such as the AXI4 ROM, for boot loading, table fetch or DMA-style copy. Exactly one burst is outstanding at a time.

## Interface
- AXI_ID_WIDTH, 8, ID width
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 64, data width; power of 2, 8 to 1024
- AXI_USER_WIDTH, 1, user width
- AR_ID, 0, constant ID driven on arid and expected on rid
- aclk  in  1  clock; single clock domain
- aresetn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1 each  command handshake
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(AXI_DATA_WIDTH/8) bits are forced to 0
- cmd_beats  in  16  total beats, 0 to 65535
- m_axi_arid, araddr, arlen[8], arsize[3], arburst[2], arlock, arcache[4], arprot[3], arqos[4], arregion[4], aruser  out  AR payload
- m_axi_arvalid  out  1 / m_axi_arready  in  1
- m_axi_rid, rdata, rresp[2], rlast, ruser  in  R payload
- m_axi_rvalid  in  1 / m_axi_rready  out  1
- out_data  out  AXI_DATA_WIDTH  read data
- out_valid  out  1 / out_ready  in  1 / out_last  out  1  last beat of the command
- done  out  1  one-cycle pulse when the command completes
- err  out  3  sticky: [0] rresp≠OKAY, [1] rid≠AR_ID, [2] rlast mismatch
- busy  out  1  state≠IDLE

## Operation
- FSM states: IDLE, AR, R, DONE.
- IDLE: cmd_ready=1. On a handshake:
  - Register the aligned address and the remaining count (rem=cmd_beats). Clear err.
  - If cmd_beats=0, go to DONE with no AXI traffic. Otherwise go to AR.
- AR entry: compute blen = min(rem, 256, (4096−addr[11:0])>>log2(bytes per beat)) and register it.
  - Drive arvalid=1, araddr=addr, arlen=blen−1, arsize=log2(bytes per beat), arburst=INCR(01).
  - Drive arid=AR_ID. arlock, arcache, arprot, arqos, arregion and aruser are all 0.
  - Hold the payload stable until arready. On the handshake go to R.
- R: pure combinational pass-through.
  - out_valid=rvalid, out_data=rdata, rready=out_ready.
  - A beat completes when rvalid&rready. On each beat, decrement the burst and total counters.
  - out_last = rvalid & (rem==1).
- Burst end is determined by the internal counter, not by rlast.
  - Set err[2] if rlast≠(burst counter==1) on any beat.
  - Set err[0] if rresp≠00. Set err[1] if rid≠AR_ID.
  - Data is still forwarded when any error bit is set.
- After the last beat of a burst:
  - addr += blen×bytes per beat.
  - If rem>0, go to AR; otherwise go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. cmd_ready=0 in DONE.
- err holds its value until the next command is accepted.

## Timing
- Reset values: arvalid=0, rready=0, out_valid=0, out_last=0, done=0, err=0, busy=0, cmd_ready=1 (state IDLE). All AR payload registers are 0.
- cmd handshake at cycle N: arvalid=1 at N+1.
- arready at cycle M: rready may go high at M+1.
- Last R beat at cycle K:
  - Next burst: arvalid=1 at K+1.
  - Final burst: done=1 at K+1, cmd_ready=1 at K+2.
- Zero-beat command accepted at N: done=1 at N+1.
- Minimum idle between two bursts of one command: 1 cycle (the AR state).
- rready is never asserted outside R, and arvalid never outside AR. Beats arriving outside R are not accepted.
- When rvalid and out_ready are both high in R, the beat transfers in that same cycle. No buffering is added.
- Reset mid-operation: everything returns to reset values immediately; the in-flight burst is abandoned.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH. The 4 KB split guarantees no burst crosses a 4 KB boundary.

## Test plan
- DW=64, cmd 0x1000, 4 beats. Expected: one AR, addr 0x1000, arlen=3, arsize=3. Four beats out, out_last on the 4th, done one cycle later, err=0.
- cmd 0x0FF0, 4 beats. Expected: AR addr 0xFF0 arlen=1, then AR addr 0x1000 arlen=1. out_last only on beat 4.
- cmd 0x0, 300 beats. Expected: AR addr 0x0 arlen=255, then AR addr 0x800 arlen=43. 300 beats in order, single done.
- Random out_ready (≈50%) and random arready delay, 16 beats. Expected: data sequence intact; rready mirrors out_ready; AR payload stable while stalled.
- Slave returns SLVERR on beat 2 of 4, then rlast early on beat 3 of a later command. Expected: err=001 after the first command, cleared on the next accept, then err=100.
- cmd_beats=0: done at N+1, no arvalid. Assert aresetn low mid-burst: arvalid, rready and out_valid go 0 immediately, busy=0, and the next command runs cleanly.

Source files
------------

// File: rtl/axi4_master_rd_burst.sv
// ---------------------------------------------------------------------------
// axi4_master_rd_burst
//
// Purpose:
//   Command-driven AXI4 read initiator. One command (start address, beat
//   count) becomes a sequence of INCR read bursts. Each burst is at most 256
//   beats and never crosses a 4 KB boundary. Only one burst is outstanding at
//   a time. Returned read data passes straight through to a valid/ready
//   output port with no buffering.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_addr, cmd_beats   start byte address (aligned internally), beat count
//   m_axi_ar*             AXI4 read-address channel (initiator side)
//   m_axi_r*              AXI4 read-data channel (initiator side)
//   out_data/out_valid/out_ready/out_last   read data stream
//   done                  one-cycle pulse when a command completes
//   err                   sticky: [0] bad rresp, [1] bad rid, [2] rlast mismatch
//   busy                  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module axi4_master_rd_burst #(
    parameter int          AXI_ID_WIDTH   = 8,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          AXI_USER_WIDTH = 1,
    parameter int unsigned AR_ID          = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]               cmd_beats,
    // AXI4 AR channel
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic [AXI_USER_WIDTH-1:0] m_axi_aruser,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // AXI4 R channel
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic [AXI_USER_WIDTH-1:0] m_axi_ruser,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    // output stream
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    // status
    output logic                      done,
    output logic [2:0]                err,
    output logic                      busy
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = {AXI_ADDR_WIDTH{1'b1}} << SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]                  arlen_q, arlen_d;
    logic [2:0]                  arsize_q, arsize_d;
    logic [1:0]                  arburst_q, arburst_d;
    logic [15:0]                 rem_q, rem_d;      // beats left in the command
    logic [8:0]                  blen_q, blen_d;    // length of current burst
    logic [8:0]                  bcnt_q, bcnt_d;    // beats left in current burst
    logic [2:0]                  err_q, err_d;

    logic [AXI_ADDR_WIDTH-1:0]   next_addr;
    logic [15:0]                 rem_dec;
    logic [AXI_ADDR_WIDTH-1:0]   sel_addr;
    logic [15:0]                 sel_rem;
    logic [8:0]                  blen_new;
    logic                        load_ar;
    logic                        r_beat;

    // Burst length: the smallest of remaining beats, 256, and the beats left
    // before the next 4 KB boundary.
    function automatic logic [8:0] calc_blen(input logic [11:0] a_lo, input logic [15:0] r);
        logic [12:0] room_bytes;
        logic [12:0] room_beats;
        logic [8:0]  cap;
        room_bytes = 13'd4096 - {1'b0, a_lo};
        room_beats = room_bytes >> SIZE;
        cap        = (r > 16'd256) ? 9'd256 : r[8:0];
        if (room_beats < {4'b0, cap}) begin
            cap = room_beats[8:0];
        end
        return cap;
    endfunction

    // Address/count feeding the next AR: the command itself when leaving
    // IDLE, otherwise the continuation after the burst that just finished.
    assign next_addr = araddr_q + (AXI_ADDR_WIDTH'(blen_q) << SIZE);
    assign rem_dec   = rem_q - 16'd1;
    assign sel_addr  = (state_q == S_IDLE) ? (cmd_addr & ALIGN_MASK) : next_addr;
    assign sel_rem   = (state_q == S_IDLE) ? cmd_beats : rem_dec;
    assign blen_new  = calc_blen(sel_addr[11:0], sel_rem);
    assign r_beat    = m_axi_rvalid & out_ready;

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arsize_d      = arsize_q;
        arburst_d     = arburst_q;
        rem_d         = rem_q;
        blen_d        = blen_q;
        bcnt_d        = bcnt_q;
        err_d         = err_q;
        load_ar       = 1'b0;
        cmd_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rem_d = cmd_beats;
                    err_d = 3'b000;
                    if (cmd_beats == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AR;
                        load_ar = 1'b1;
                    end
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                m_axi_rready = out_ready;
                out_valid    = m_axi_rvalid;
                out_last     = m_axi_rvalid & (rem_q == 16'd1);
                if (r_beat) begin
                    // rlast is only audited; the burst ends on the counter.
                    err_d  = err_q | {m_axi_rlast != (bcnt_q == 9'd1),
                                      m_axi_rid != AXI_ID_WIDTH'(AR_ID),
                                      m_axi_rresp != 2'b00};
                    bcnt_d = bcnt_q - 9'd1;
                    rem_d  = rem_dec;
                    if (bcnt_q == 9'd1) begin
                        if (rem_dec != 16'd0) begin
                            state_d = S_AR;
                            load_ar = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_ar) begin
            araddr_d  = sel_addr;
            arlen_d   = 8'(blen_new - 9'd1);
            arsize_d  = 3'(SIZE);
            arburst_d = 2'b01;
            blen_d    = blen_new;
            bcnt_d    = blen_new;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rem_q     <= '0;
            blen_q    <= '0;
            bcnt_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rem_q     <= rem_d;
            blen_q    <= blen_d;
            bcnt_q    <= bcnt_d;
            err_q     <= err_d;
        end
    end

    assign m_axi_arid     = AXI_ID_WIDTH'(AR_ID);
    assign m_axi_araddr   = araddr_q;
    assign m_axi_arlen    = arlen_q;
    assign m_axi_arsize   = arsize_q;
    assign m_axi_arburst  = arburst_q;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0000;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arqos    = 4'b0000;
    assign m_axi_arregion = 4'b0000;
    assign m_axi_aruser   = '0;

    assign out_data = m_axi_rdata;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);

    // ruser carries nothing this initiator needs.
    logic unused_ruser;
    assign unused_ruser = ^m_axi_ruser;

endmodule

// File: tb/tb_axi4_master_rd_burst.sv
// ---------------------------------------------------------------------------
// tb_axi4_master_rd_burst
//
// Directed bench for axi4_master_rd_burst (64-bit data). A behavioural AXI
// read slave returns {~addr, addr} for each beat address; a consumer drains
// the output stream and compares every beat against the command's own start
// address. AR requests are logged and compared against hand-computed splits.
// ---------------------------------------------------------------------------
module tb_axi4_master_rd_burst;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [7:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic [3:0]  m_axi_arregion;
    logic [0:0]  m_axi_aruser;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [7:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic [0:0]  m_axi_ruser;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;
    logic [2:0]  err;
    logic        busy;

    axi4_master_rd_burst dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arregion(m_axi_arregion),
        .m_axi_aruser  (m_axi_aruser),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_ruser   (m_axi_ruser),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .done          (done),
        .err           (err),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;

    // shared scoreboard state
    logic [31:0] exp_base;
    int          exp_total;
    int          beat_idx;
    int          done_cnt;
    bit          rand_mode = 0;
    int          inj_resp_beat = -1;
    int          inj_rlast_beat = -1;
    int          sl_beat;
    int          ar_cnt;
    logic [31:0] ar_addr_log [0:7];
    logic [7:0]  ar_len_log  [0:7];
    logic [2:0]  ar_size_log [0:7];
    logic [1:0]  ar_burst_log[0:7];
    logic [24:0] ar_misc_log [0:7];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    // ---------------- AXI read slave ----------------
    initial begin : slave
        logic [31:0] cap_addr;
        int          cap_len;
        int          dly;
        bit          abort;
        bit          hs;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rid     = 8'd0;
        m_axi_ruser   = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn && m_axi_arvalid) begin
                cap_addr = m_axi_araddr;
                cap_len  = int'(m_axi_arlen);
                if (ar_cnt < 8) begin
                    ar_addr_log[ar_cnt]  = m_axi_araddr;
                    ar_len_log[ar_cnt]   = m_axi_arlen;
                    ar_size_log[ar_cnt]  = m_axi_arsize;
                    ar_burst_log[ar_cnt] = m_axi_arburst;
                    ar_misc_log[ar_cnt]  = {m_axi_arid, m_axi_arlock, m_axi_arcache, m_axi_arprot,
                                            m_axi_arqos, m_axi_arregion, m_axi_aruser};
                end
                ar_cnt++;
                abort = 0;
                dly   = rand_mode ? int'($urandom_range(0, 3)) : 0;
                for (int i = 0; i < dly && !abort; i++) begin
                    @(negedge aclk);
                    if (!aresetn) abort = 1;
                    else begin
                        check_val("ar_hold_valid", m_axi_arvalid, 1);
                        check_val("ar_hold_addr", m_axi_araddr, cap_addr);
                        check_val("ar_hold_len", m_axi_arlen, cap_len);
                    end
                end
                if (!abort) begin
                    m_axi_arready = 1'b1;
                    @(posedge aclk); #1;
                    m_axi_arready = 1'b0;
                    for (int b = 0; b <= cap_len && !abort; b++) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = beat_word(cap_addr + 32'(b * 8));
                        m_axi_rlast  = (b == cap_len) ^ (sl_beat == inj_rlast_beat);
                        m_axi_rresp  = (sl_beat == inj_resp_beat) ? 2'b10 : 2'b00;
                        hs = 0;
                        while (!hs && !abort) begin
                            @(negedge aclk);
                            if (!aresetn) abort = 1;
                            else hs = m_axi_rready;
                            @(posedge aclk); #1;
                        end
                        if (hs) sl_beat++;
                    end
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
            end
        end
    end

    // ---------------- output consumer ----------------
    initial begin : consumer
        bit pending_done;
        pending_done = 0;
        out_ready    = 1'b0;
        forever begin
            @(posedge aclk); #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (aresetn) begin
                if (pending_done) begin
                    check_val("done_after_last", done, 1);
                    pending_done = 0;
                end
                if (done) done_cnt++;
                if (out_valid) begin
                    check_val("rready_mirror", m_axi_rready, out_ready);
                    if (out_ready) begin
                        check_val("out_data", out_data, beat_word(exp_base + 32'(beat_idx * 8)));
                        check_val("out_last", out_last, beat_idx == exp_total - 1);
                        $display("beat %0d data=%h last=%0b", beat_idx, out_data, out_last);
                        if (beat_idx == exp_total - 1) pending_done = 1;
                        beat_idx++;
                    end
                end
            end else begin
                pending_done = 0;
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] addr, input int beats);
        exp_base  = addr & 32'hFFFF_FFF8;
        exp_total = beats;
        beat_idx  = 0;
        done_cnt  = 0;
        ar_cnt    = 0;
        sl_beat   = 0;
        @(posedge aclk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_beats = 16'(beats);
        @(negedge aclk);
        check_val("cmd_ready", cmd_ready, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        @(negedge aclk);
        check_val("err_clear_on_accept", err, 0);
        if (beats != 0) begin
            check_val("arvalid_n1", m_axi_arvalid, 1);
        end else begin
            check_val("zero_done_n1", done, 1);
            check_val("zero_no_ar", m_axi_arvalid, 0);
        end
        $display("cmd addr=%h beats=%0d accepted", addr, beats);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge aclk);
        end
        check_val("done_seen", seen, 1);
        @(negedge aclk);
        check_val("done_pulse", done, 0);
        check_val("cmd_ready_after", cmd_ready, 1);
        check_val("beat_count", beat_idx, exp_total);
        check_val("done_count", done_cnt, 1);
        $display("cmd done beats=%0d ars=%0d err=%b", beat_idx, ar_cnt, err);
    endtask

    initial begin : main
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        ar_cnt    = 0;
        exp_total = 0;
        beat_idx  = 0;
        done_cnt  = 0;
        sl_beat   = 0;
        exp_base  = '0;
        repeat (3) @(negedge aclk);
        check_val("rst_arvalid", m_axi_arvalid, 0);
        check_val("rst_rready", m_axi_rready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_araddr", m_axi_araddr, 0);
        check_val("rst_arlen", m_axi_arlen, 0);
        check_val("rst_arsize", m_axi_arsize, 0);
        check_val("rst_arburst", m_axi_arburst, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // single aligned burst
        issue_cmd(32'h0000_1000, 4);
        wait_done();
        check_val("t1_ar_cnt", ar_cnt, 1);
        check_val("t1_addr", ar_addr_log[0], 32'h1000);
        check_val("t1_len", ar_len_log[0], 3);
        check_val("t1_size", ar_size_log[0], 3);
        check_val("t1_burst", ar_burst_log[0], 1);
        check_val("t1_misc", ar_misc_log[0], 0);
        check_val("t1_err", err, 0);

        // 4 KB split
        issue_cmd(32'h0000_0FF0, 4);
        wait_done();
        check_val("t2_ar_cnt", ar_cnt, 2);
        check_val("t2_addr0", ar_addr_log[0], 32'h0FF0);
        check_val("t2_len0", ar_len_log[0], 1);
        check_val("t2_addr1", ar_addr_log[1], 32'h1000);
        check_val("t2_len1", ar_len_log[1], 1);

        // 256-beat split
        issue_cmd(32'h0000_0000, 300);
        wait_done();
        check_val("t3_ar_cnt", ar_cnt, 2);
        check_val("t3_addr0", ar_addr_log[0], 32'h0000);
        check_val("t3_len0", ar_len_log[0], 255);
        check_val("t3_addr1", ar_addr_log[1], 32'h0800);
        check_val("t3_len1", ar_len_log[1], 43);

        // random backpressure, unaligned command address, 4 KB split
        rand_mode = 1;
        issue_cmd(32'h0000_2FC5, 16);
        wait_done();
        rand_mode = 0;
        check_val("t4_ar_cnt", ar_cnt, 2);
        check_val("t4_addr0", ar_addr_log[0], 32'h2FC0);
        check_val("t4_len0", ar_len_log[0], 7);
        check_val("t4_addr1", ar_addr_log[1], 32'h3000);
        check_val("t4_len1", ar_len_log[1], 7);

        // SLVERR on beat 2, then early rlast on beat 3 of the next command
        inj_resp_beat = 1;
        issue_cmd(32'h0000_0100, 4);
        wait_done();
        inj_resp_beat = -1;
        check_val("t5_err_resp", err, 3'b001);
        inj_rlast_beat = 2;
        issue_cmd(32'h0000_0200, 4);
        wait_done();
        inj_rlast_beat = -1;
        check_val("t5_err_rlast", err, 3'b100);

        // zero-beat command
        issue_cmd(32'h0000_0040, 0);
        wait_done();
        check_val("t6_ar_cnt", ar_cnt, 0);
        check_val("t6_err", err, 0);

        // reset in the middle of a burst
        issue_cmd(32'h0000_0500, 8);
        for (int i = 0; i < 200 && beat_idx < 3; i++) @(negedge aclk);
        check_val("t7_reached_mid", beat_idx >= 3, 1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        check_val("t7_arvalid", m_axi_arvalid, 0);
        check_val("t7_rready", m_axi_rready, 0);
        check_val("t7_out_valid", out_valid, 0);
        check_val("t7_busy", busy, 0);
        check_val("t7_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        issue_cmd(32'h0000_1000, 4);
        wait_done();
        check_val("t7_ar_cnt", ar_cnt, 1);
        check_val("t7_addr", ar_addr_log[0], 32'h1000);
        check_val("t7_len", ar_len_log[0], 3);
        check_val("t7_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
